// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: state encoding and
// default counter width.
package interval_timer_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Control word handed from the sequencer to the counter datapath.
  typedef struct packed {
    logic clr;
    logic en;
  } cnt_ctrl_t;

endpackage : interval_timer_ctrl_pkg

// File: rtl/interval_timer_ctrl_sync_up_counter.sv
// Synchronous up counter datapath; a clear takes priority over an enable.
module sync_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] Q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else if (clr) begin
      Q <= '0;
    end else if (en) begin
      Q <= Q + WIDTH'(1);
    end
  end

endmodule : sync_up_counter

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer sequencer: start/stop, one-shot or periodic,
// single-cycle registered tick at terminal count; owns the counter clr/en.
module interval_timer_ctrl
  import interval_timer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic             busy,
  output logic             tick,
  output logic [WIDTH-1:0] Q
);

  state_e           state, state_n;
  logic [WIDTH-1:0] limit_q;
  logic             periodic_q;
  logic             tick_n;
  logic             latch;
  logic             at_terminal;
  cnt_ctrl_t        cnt_ctrl;

  sync_up_counter #(.WIDTH(WIDTH)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_ctrl.clr),
    .en      (cnt_ctrl.en),
    .Q       (Q)
  );

  // Compare precedes increment, so the counter never wraps on its own.
  assign at_terminal = (Q == limit_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tick       <= 1'b0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      if (latch) begin
        limit_q    <= limit;
        periodic_q <= periodic;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n      = state;
    tick_n       = 1'b0;
    latch        = 1'b0;
    cnt_ctrl.clr = 1'b0;
    cnt_ctrl.en  = 1'b0;

    if (stop) begin
      // Abort wins over start and terminal count; no tick on this edge.
      state_n      = ST_IDLE;
      cnt_ctrl.clr = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE, ST_HOLD: begin
          if (start) begin
            latch        = 1'b1;
            cnt_ctrl.clr = 1'b1;
            state_n      = ST_RUN;
          end
        end
        ST_RUN: begin
          if (at_terminal) begin
            tick_n = 1'b1;
            if (periodic_q) begin
              cnt_ctrl.clr = 1'b1;
            end else begin
              state_n = ST_HOLD;
            end
          end else begin
            cnt_ctrl.en = 1'b1;
          end
        end
        default: begin
          state_n      = ST_IDLE;
          cnt_ctrl.clr = 1'b1;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN);

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl (WIDTH = 4).
module tb_interval_timer_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start, stop, periodic;
  logic [W-1:0] limit;
  logic         busy, tick;
  logic [W-1:0] q;

  int tests_run    = 0;
  int tests_failed = 0;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .busy     (busy),
    .tick     (tick),
    .Q        (q)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept start at the next edge (edge 0), then drop start.
  task automatic launch(input logic [W-1:0] lim, input logic per);
    limit    = lim;
    periodic = per;
    start    = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", busy, tick, q);
    end
  endtask

  task automatic test_one_shot();
    launch(4'd5, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      tests_run++;
      if ({busy, tick, q} !== {1'b1, 1'b0, 4'(k)}) begin
        tests_failed++;
        $display("FAIL one_shot edge %0d: got busy=%0b tick=%0b Q=%0d, expected 1 0 %0d", k, busy, tick, q, k);
      end
    end
    step();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b1, 4'd5}) begin
      tests_failed++;
      $display("FAIL one_shot terminal: got busy=%0b tick=%0b Q=%0d, expected 0 1 5", busy, tick, q);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if ({busy, tick, q} !== {1'b0, 1'b0, 4'd5}) begin
        tests_failed++;
        $display("FAIL one_shot hold %0d: got busy=%0b tick=%0b Q=%0d, expected 0 0 5", k, busy, tick, q);
      end
    end
  endtask

  task automatic test_restart_from_hold();
    launch(4'd1, 1'b0);
    tests_run++;
    if ({busy, tick, q} !== {1'b1, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL restart: got busy=%0b tick=%0b Q=%0d, expected 1 0 0", busy, tick, q);
    end
    abort();
  endtask

  task automatic test_periodic();
    launch(4'd3, 1'b1);
    for (int e = 1; e <= 13; e++) begin
      step();
      tests_run++;
      if ({busy, tick, q} !== {1'b1, (e % 4 == 0), 4'(e % 4)}) begin
        tests_failed++;
        $display("FAIL periodic edge %0d: got busy=%0b tick=%0b Q=%0d, expected 1 %0b %0d",
                 e, busy, tick, q, (e % 4 == 0), e % 4);
      end
    end
    abort();
  endtask

  task automatic test_stop();
    launch(4'd7, 1'b0);
    step();
    step();
    abort();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL stop_mid: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", busy, tick, q);
    end
    // Stop on the terminal-count edge must suppress the tick.
    launch(4'd2, 1'b0);
    step();
    step();
    abort();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL stop_at_terminal: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", busy, tick, q);
    end
    // Start and stop together from IDLE stays IDLE.
    limit = 4'd4;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
        tests_failed++;
        $display("FAIL start_stop_same %0d: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", k, busy, tick, q);
      end
      step();
    end
  endtask

  task automatic test_limit_zero();
    launch(4'd0, 1'b1);
    tests_run++;
    if ({busy, tick, q} !== {1'b1, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL lim0_periodic start: got busy=%0b tick=%0b Q=%0d, expected 1 0 0", busy, tick, q);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      tests_run++;
      if ({busy, tick, q} !== {1'b1, 1'b1, 4'd0}) begin
        tests_failed++;
        $display("FAIL lim0_periodic %0d: got busy=%0b tick=%0b Q=%0d, expected 1 1 0", k, busy, tick, q);
      end
    end
    abort();
    launch(4'd0, 1'b0);
    step();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b1, 4'd0}) begin
      tests_failed++;
      $display("FAIL lim0_one_shot tick: got busy=%0b tick=%0b Q=%0d, expected 0 1 0", busy, tick, q);
    end
    step();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL lim0_one_shot hold: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", busy, tick, q);
    end
  endtask

  task automatic test_limit_max();
    launch(4'd15, 1'b1);
    for (int e = 1; e <= 17; e++) begin
      step();
      tests_run++;
      if ({busy, tick, q} !== {1'b1, (e == 16), 4'(e % 16)}) begin
        tests_failed++;
        $display("FAIL limit_max edge %0d: got busy=%0b tick=%0b Q=%0d, expected 1 %0b %0d",
                 e, busy, tick, q, (e == 16), e % 16);
      end
    end
    abort();
  endtask

  task automatic test_latching();
    launch(4'd5, 1'b0);
    step();
    step();
    step();
    limit    = 4'd2;
    periodic = 1'b1;
    start    = 1'b1;
    step();
    step();
    tests_run++;
    if ({busy, tick, q} !== {1'b1, 1'b0, 4'd5}) begin
      tests_failed++;
      $display("FAIL latching count: got busy=%0b tick=%0b Q=%0d, expected 1 0 5", busy, tick, q);
    end
    start = 1'b0;
    step();
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b1, 4'd5}) begin
      tests_failed++;
      $display("FAIL latching terminal: got busy=%0b tick=%0b Q=%0d, expected 0 1 5", busy, tick, q);
    end
    abort();
  endtask

  task automatic test_reset_mid_run();
    launch(4'd9, 1'b1);
    for (int k = 0; k < 6; k++) step();
    tests_run++;
    if (q !== 4'd6) begin
      tests_failed++;
      $display("FAIL reset_mid_run setup: got Q=%0d, expected 6", q);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_run async: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", busy, tick, q);
    end
    #2 reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      tests_run++;
      if ({busy, tick, q} !== {1'b0, 1'b0, 4'd0}) begin
        tests_failed++;
        $display("FAIL reset_mid_run idle %0d: got busy=%0b tick=%0b Q=%0d, expected 0 0 0", k, busy, tick, q);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    limit    = '0;
    #3;
    test_reset();
    #9 reset_n = 1'b1;
    test_one_shot();
    test_restart_from_hold();
    test_periodic();
    test_stop();
    test_limit_zero();
    test_limit_max();
    test_latching();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_interval_timer_ctrl
